seven_seg_scan: RTL and testbench

Multiplexed multi-digit seven-segment display driver, the parametrised successor to the single-digit combinational segment decoder. It holds a committed display value of `NUM_DIGITS` nibbles and scans one digit per refresh tick. It drives shared segment lines plus a one-hot digit select. New values are accepted through a load strobe and committed only at frame boundaries, so a digit never shows a mix of old and new data. It sits between the datapath and the board's display pins.

---
 rtl/seven_seg_scan.sv | 182 ++++++++++++++++++
 tb/tb_seven_seg_scan.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan.sv
// -----------------------------------------------------------------------------
// seven_seg_scan
//
// Multiplexed multi-digit seven-segment display driver. A committed value of
// NUM_DIGITS nibbles is scanned one digit per refresh tick onto shared segment
// lines with a one-hot digit select. New values are captured by a load strobe
// into a pending register and only committed at a frame boundary, so a digit
// never shows a mix of old and new data.
//
// Parameters
//   NUM_DIGITS  number of digits scanned (1..8)
//   DIV         clocks per refresh tick, i.e. per-digit dwell (>= 1)
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   load        one-cycle strobe, captures data_in/dp_in as pending value
//   data_in     nibble k drives digit k, digit 0 least significant
//   dp_in       decimal-point enable per digit
//   hex_mode    1: decode 0-F, 0: BCD with 10-15 blank (sampled live)
//   seg         segments {a,b,c,d,e,f,g}, MSB = a, active-high
//   dp          decimal point of the selected digit, active-high
//   dig         one-hot digit select, active-high
//   pending     a loaded value is waiting for commit
//   frame_done  one-cycle pulse after each full scan
//
// Build option
//   SEVEN_SEG_LZ_BLANK_EN  when defined, leading zero digits (from the top
//                          digit downward, never digit 0) are blanked.
// -----------------------------------------------------------------------------
module seven_seg_scan #(
    parameter int NUM_DIGITS = 4,
    parameter int DIV        = 50000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    hex_mode,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   dig,
    output logic                    pending,
    output logic                    frame_done
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PW-1:0] PCNT_LAST = PW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]           pcnt;
    logic [IW-1:0]           idx;
    logic                    tick;
    logic                    wrap;

    logic [4*NUM_DIGITS-1:0] pend_data;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic [4*NUM_DIGITS-1:0] com_data;
    logic [NUM_DIGITS-1:0]   com_dp;

    logic [3:0]              cur_nib;
    logic [6:0]              cur_seg;

    // Nibble to {a..g}. In BCD mode the non-decimal codes are blanked.
    function automatic logic [6:0] decode(input logic [3:0] nib, input logic hex);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1111110;
            4'h1:    s = 7'b0110000;
            4'h2:    s = 7'b1101101;
            4'h3:    s = 7'b1111001;
            4'h4:    s = 7'b0110011;
            4'h5:    s = 7'b1011011;
            4'h6:    s = 7'b1011111;
            4'h7:    s = 7'b1110000;
            4'h8:    s = 7'b1111111;
            4'h9:    s = 7'b1111011;
            4'hA:    s = 7'b1110111;
            4'hB:    s = 7'b0011111;
            4'hC:    s = 7'b1001110;
            4'hD:    s = 7'b0111101;
            4'hE:    s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        if (!hex && (nib > 4'd9)) begin
            s = 7'b0000000;
        end
        return s;
    endfunction

    assign tick = (pcnt == PCNT_LAST);
    assign wrap = tick && (idx == IDX_LAST);

    // Prescaler and digit index.
    // NOTE: every sequential process uses non-blocking assignments so that all
    // registers update from the same pre-edge values, independent of order.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt <= '0;
            idx  <= '0;
        end else if (tick) begin
            pcnt <= '0;
            idx  <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    // Pending/committed value handling. A load in the wrap cycle bypasses the
    // pending register so the newest data is shown from the next frame on.
    // NOTE: the data registers are reset as well as the control bits, because
    // a reset must also clear what is on the display, not just the scan.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_data <= '0;
            pend_dp   <= '0;
            com_data  <= '0;
            com_dp    <= '0;
            pending   <= 1'b0;
        end else if (load && wrap) begin
            com_data  <= data_in;
            com_dp    <= dp_in;
            pending   <= 1'b0;
        end else if (load) begin
            pend_data <= data_in;
            pend_dp   <= dp_in;
            pending   <= 1'b1;
        end else if (wrap && pending) begin
            com_data  <= pend_data;
            com_dp    <= pend_dp;
            pending   <= 1'b0;
        end
    end

`ifdef SEVEN_SEG_LZ_BLANK_EN
    // Blank mask from the committed value: digit k (k >= 1) is blanked while
    // it and every digit above it are zero. Digit 0 is never blanked.
    logic [NUM_DIGITS-1:0] blank;
    logic                  zero_run;

    always_comb begin
        blank    = '0;
        zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run = zero_run && (com_data[4*k +: 4] == 4'd0);
            blank[k] = zero_run;
        end
    end
`endif

    // Segment pattern for the digit currently selected by idx.
    // NOTE: outputs of a combinational process are given a default first so
    // that no path leaves them unassigned and no latch is inferred.
    always_comb begin
        cur_nib = com_data[4*int'(idx) +: 4];
        cur_seg = decode(cur_nib, hex_mode);
`ifdef SEVEN_SEG_LZ_BLANK_EN
        if (blank[idx]) begin
            cur_seg = 7'b0000000;
        end
`endif
    end

    // Registered display outputs; they lag idx by one clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg        <= '0;
            dp         <= 1'b0;
            dig        <= '0;
            frame_done <= 1'b0;
        end else begin
            seg        <= cur_seg;
            dp         <= com_dp[idx];
            dig        <= NUM_DIGITS'(1) << idx;
            frame_done <= wrap;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_scan
//
// Self-checking bench for seven_seg_scan with NUM_DIGITS=4, DIV=4. A reference
// model tracks the cycle count since reset: the displayed digit is
// (n / DIV) % NUM_DIGITS and a frame boundary is every DIV*NUM_DIGITS cycles.
// Loads are applied to the model by the commit rules, and every cycle the DUT
// outputs are compared with the model. Directed sequences cover the listed
// scenarios, followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_seven_seg_scan;

    localparam int N   = 4;
    localparam int DIV = 4;
    localparam int FRAME = N * DIV;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           load = 1'b0;
    logic [4*N-1:0] data_in = '0;
    logic [N-1:0]   dp_in = '0;
    logic           hex_mode = 1'b0;
    logic [6:0]     seg;
    logic           dp;
    logic [N-1:0]   dig;
    logic           pending;
    logic           frame_done;

    seven_seg_scan #(
        .NUM_DIGITS (N),
        .DIV        (DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .hex_mode   (hex_mode),
        .seg        (seg),
        .dp         (dp),
        .dig        (dig),
        .pending    (pending),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Segment table {a..g}, indexed by nibble value.
    logic [6:0] seg_tab [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    // Reference model state.
    int             n;
    logic [4*N-1:0] m_com;
    logic [N-1:0]   m_com_dp;
    logic [4*N-1:0] m_pend_val;
    logic [N-1:0]   m_pend_dp;
    logic           m_pend;

    int errors = 0;
    int checks = 0;
    logic cur_hex = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", tag, got, exp, n, $time);
        end
    endtask

    function automatic logic [6:0] exp_seg(input logic [4*N-1:0] val, input int k, input logic h);
        logic [3:0] nib;
        int         top;
        nib = val[4*k +: 4];
        top = 0;
        for (int j = 0; j < N; j++) begin
            if (val[4*j +: 4] != 4'd0) top = j;
        end
`ifdef SEVEN_SEG_LZ_BLANK_EN
        if (k > top) return 7'b0000000;
`endif
        if (!h && nib > 4'd9) return 7'b0000000;
        return seg_tab[nib];
    endfunction

    task automatic model_reset();
        n          = 0;
        m_com      = '0;
        m_com_dp   = '0;
        m_pend_val = '0;
        m_pend_dp  = '0;
        m_pend     = 1'b0;
    endtask

    // One clock: drive inputs after the falling edge, advance the model over
    // the rising edge, then compare outputs just after that edge.
    task automatic run_cycle(input logic r, input logic ld, input logic [4*N-1:0] d,
                             input logic [N-1:0] p, input logic h);
        logic [6:0]   e_seg;
        logic         e_dp;
        logic [N-1:0] e_dig;
        logic         e_fd;
        int           k;
        logic         w;
        @(negedge clk);
        rst      = r;
        load     = ld;
        data_in  = d;
        dp_in    = p;
        hex_mode = h;
        if (r) begin
            e_seg = '0;
            e_dp  = 1'b0;
            e_dig = '0;
            e_fd  = 1'b0;
            model_reset();
        end else begin
            k     = (n / DIV) % N;
            e_seg = exp_seg(m_com, k, h);
            e_dp  = m_com_dp[k];
            e_dig = N'(1) << k;
            w     = ((n % FRAME) == FRAME - 1);
            e_fd  = w;
            if (ld && w) begin
                m_com    = d;
                m_com_dp = p;
                m_pend   = 1'b0;
            end else if (ld) begin
                m_pend_val = d;
                m_pend_dp  = p;
                m_pend     = 1'b1;
            end else if (w && m_pend) begin
                m_com    = m_pend_val;
                m_com_dp = m_pend_dp;
                m_pend   = 1'b0;
            end
            n++;
        end
        @(posedge clk);
        #1;
        check("seg",        32'(seg),        32'(e_seg));
        check("dp",         32'(dp),         32'(e_dp));
        check("dig",        32'(dig),        32'(e_dig));
        check("pending",    32'(pending),    32'(m_pend));
        check("frame_done", 32'(frame_done), 32'(e_fd));
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) run_cycle(1'b0, 1'b0, '0, '0, cur_hex);
    endtask

    task automatic advance_to(input int phase);
        for (int i = 0; i < FRAME && (n % FRAME) != phase; i++) idle(1);
    endtask

    task automatic do_load(input logic [4*N-1:0] d, input logic [N-1:0] p);
        run_cycle(1'b0, 1'b1, d, p, cur_hex);
    endtask

    initial begin
        model_reset();

        // Reset state, then a blank scan of value 0 over several frames.
        for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b0, '0, '0, 1'b1);
        idle(2 * FRAME + 5);

        // Mid-frame load, committed at the next wrap.
        advance_to(5);
        do_load(16'h1234, 4'b0100);
        idle(2 * FRAME);

        // Two loads in one frame: only the last is ever shown.
        advance_to(2);
        do_load(16'h1111, 4'b0001);
        idle(3);
        do_load(16'h2222, 4'b0010);
        idle(2 * FRAME);

        // Load coincident with wrap commits immediately.
        advance_to(FRAME - 1);
        do_load(16'h5678, 4'b1000);
        idle(FRAME + 2);

        // Hex letters, then the same data in BCD mode.
        do_load(16'hABCD, 4'b0000);
        idle(2 * FRAME);
        cur_hex = 1'b0;
        idle(FRAME);
        cur_hex = 1'b1;

        // Leading zeros and an all-zero value.
        do_load(16'h0042, 4'b1001);
        idle(2 * FRAME);
        do_load(16'h0000, 4'b0000);
        idle(2 * FRAME);

        // Reset mid-frame while a load is pending.
        advance_to(6);
        do_load(16'h9999, 4'b1111);
        run_cycle(1'b1, 1'b0, '0, '0, cur_hex);
        idle(FRAME + 3);

        // Randomized traffic with occasional resets and live hex_mode changes.
        for (int i = 0; i < 3000; i++) begin
            logic r;
            logic ld;
            r  = ($urandom_range(0, 299) == 0);
            ld = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 49) == 0) cur_hex = ~cur_hex;
            run_cycle(r, ld, 16'($urandom), 4'($urandom), cur_hex);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
